// File: rtl/tpu_host_bridge_pkg.sv
// rtl/tpu_host_bridge_pkg.sv - shared widths and FSM encoding for the TPU host bridge
`ifndef TPU_HOST_BRIDGE_DEFS
`define TPU_HOST_BRIDGE_DEFS
`define ADDR_WIDTH 8
`define WORD_WIDTH 16
`endif

package tpu_host_bridge_pkg;
  localparam int AW = `ADDR_WIDTH;
  localparam int WW = `WORD_WIDTH;

  localparam logic [AW-1:0] AW_ONE = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_READ_P = 3'd5;
  localparam logic [2:0] ST_DRAIN  = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD_A = ST_LOAD_A,
    LOAD_B = ST_LOAD_B,
    START  = ST_START,
    WAIT   = ST_WAIT,
    READ_P = ST_READ_P,
    DRAIN  = ST_DRAIN
  } state_e;
endpackage

// File: rtl/stream_skid.sv
// rtl/stream_skid.sv - two-entry valid/ready buffer carrying a word plus its last flag
module stream_skid
  import tpu_host_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [WW:0] s_data_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [WW:0] m_data_o,
  output logic [1:0]  level_o
);
  logic [WW:0] e0_q, e1_q;
  logic [1:0]  level_q;
  logic        push, pop;

  // A full buffer still accepts when the head leaves in the same cycle.
  assign s_ready_o = (level_q != 2'd2) | m_ready_i;
  assign m_valid_o = (level_q != 2'd0);
  assign m_data_o  = e0_q;
  assign level_o   = level_q;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = m_valid_o & m_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q    <= '0;
      e1_q    <= '0;
      level_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (level_q == 2'd0) e0_q <= s_data_i;
          else                 e1_q <= s_data_i;
          level_q <= level_q + 2'd1;
        end
        2'b01: begin
          e0_q    <= e1_q;
          level_q <= level_q - 2'd1;
        end
        2'b11: begin
          if (level_q == 2'd1) begin
            e0_q <= s_data_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= s_data_i;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/tpu_host_bridge.sv
// rtl/tpu_host_bridge.sv - loads A/B buffers from a stream, kicks the TPU, streams P back out
module tpu_host_bridge
  import tpu_host_bridge_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  input  logic [AW-1:0] m_i, k_i, n_i,
  input  logic [AW-1:0] base_addra_i, base_addrb_i, base_addrp_i,
  input  logic [AW-1:0] lena_i, lenb_i, lenp_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          s_valid_i,
  input  logic [WW-1:0] s_data_i,
  output logic          s_ready_o,
  output logic          m_valid_o,
  output logic [WW-1:0] m_data_o,
  output logic          m_last_o,
  input  logic          m_ready_i,
  output logic          ena_o, wea_o,
  output logic [AW-1:0] addra_o,
  output logic [WW-1:0] worda_o,
  output logic          enb_o, web_o,
  output logic [AW-1:0] addrb_o,
  output logic [WW-1:0] wordb_o,
  output logic          enp_o, wep_o,
  output logic [AW-1:0] addrp_o,
  input  logic [WW-1:0] wordp_i,
  output logic          tpu_start_o,
  input  logic          tpu_valid_i,
  output logic [AW-1:0] tpu_m_o, tpu_k_o, tpu_n_o,
  output logic [AW-1:0] tpu_base_addra_o, tpu_base_addrb_o, tpu_base_addrp_o
);
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] lena_q, lenb_q, lenp_q;
  logic          done_q, done_d;
  logic          inflight_q, inflight_last_q;
  logic          issue;
  logic          skid_ready, skid_valid, pop;
  logic [WW:0]   skid_data;
  logic [1:0]    skid_level;
  logic [2:0]    credit;

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign wep_o     = 1'b0;
  assign m_valid_o = skid_valid;
  assign m_data_o  = skid_data[WW-1:0];
  assign m_last_o  = skid_data[WW] & skid_valid;
  assign pop       = skid_valid & m_ready_i;
  // Occupancy the buffer will see once the outstanding read lands, after this cycle's pop.
  assign credit    = {1'b0, skid_level} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    s_ready_o   = 1'b0;
    ena_o       = 1'b0;
    wea_o       = 1'b0;
    addra_o     = '0;
    worda_o     = '0;
    enb_o       = 1'b0;
    web_o       = 1'b0;
    addrb_o     = '0;
    wordb_o     = '0;
    enp_o       = 1'b0;
    addrp_o     = '0;
    tpu_start_o = 1'b0;
    case (state_q)
      IDLE: if (go_i) begin
        cnt_d = '0;
        if (lena_i != '0)      state_d = LOAD_A;
        else if (lenb_i != '0) state_d = LOAD_B;
        else                   state_d = START;
      end
      LOAD_A: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          ena_o   = 1'b1;
          wea_o   = 1'b1;
          addra_o = tpu_base_addra_o + cnt_q;
          worda_o = s_data_i;
          cnt_d   = cnt_q + AW_ONE;
          if (cnt_q == lena_q - AW_ONE) begin
            cnt_d   = '0;
            state_d = (lenb_q != '0) ? LOAD_B : START;
          end
        end
      end
      LOAD_B: begin
        s_ready_o = 1'b1;
        if (s_valid_i) begin
          enb_o   = 1'b1;
          web_o   = 1'b1;
          addrb_o = tpu_base_addrb_o + cnt_q;
          wordb_o = s_data_i;
          cnt_d   = cnt_q + AW_ONE;
          if (cnt_q == lenb_q - AW_ONE) begin
            cnt_d   = '0;
            state_d = START;
          end
        end
      end
      START: begin
        tpu_start_o = 1'b1;
        state_d     = WAIT;
      end
      WAIT: if (tpu_valid_i) begin
        cnt_d   = '0;
        state_d = (lenp_q != '0) ? READ_P : DRAIN;
      end
      READ_P: if (credit < 3'd2 && skid_ready) begin
        issue   = 1'b1;
        enp_o   = 1'b1;
        addrp_o = tpu_base_addrp_o + cnt_q;
        cnt_d   = cnt_q + AW_ONE;
        if (cnt_q == lenp_q - AW_ONE) state_d = DRAIN;
      end
      DRAIN: if (lenp_q == '0 || (pop && skid_data[WW])) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      done_q           <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_last_q  <= 1'b0;
      lena_q           <= '0;
      lenb_q           <= '0;
      lenp_q           <= '0;
      tpu_m_o          <= '0;
      tpu_k_o          <= '0;
      tpu_n_o          <= '0;
      tpu_base_addra_o <= '0;
      tpu_base_addrb_o <= '0;
      tpu_base_addrp_o <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (cnt_q == lenp_q - AW_ONE);
      if (state_q == IDLE && go_i) begin
        lena_q           <= lena_i;
        lenb_q           <= lenb_i;
        lenp_q           <= lenp_i;
        tpu_m_o          <= m_i;
        tpu_k_o          <= k_i;
        tpu_n_o          <= n_i;
        tpu_base_addra_o <= base_addra_i;
        tpu_base_addrb_o <= base_addrb_i;
        tpu_base_addrp_o <= base_addrp_i;
      end
    end
  end

  stream_skid u_skid (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .s_valid_i(inflight_q),
    .s_ready_o(skid_ready),
    .s_data_i ({inflight_last_q, wordp_i}),
    .m_valid_o(skid_valid),
    .m_ready_i(m_ready_i),
    .m_data_o (skid_data),
    .level_o  (skid_level)
  );
endmodule

// File: doc/tpu_host_bridge.md
TPU_HOST_BRIDGE -- requirements
Module: tpu_host_bridge

Interface
REQ-001 SHALL have no parameters; widths SHALL be the shared `ADDR_WIDTH (AW) and `WORD_WIDTH (WW) constants.
REQ-002 clk_i  in  1  sole clock, all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, synchronous and active-low.
REQ-004 go_i  in  1  start a job; sampled only in IDLE.
REQ-005 m_i, k_i, n_i, base_addra_i, base_addrb_i, base_addrp_i  in  AW each  job config, latched on accepted go_i.
REQ-006 lena_i, lenb_i, lenp_i  in  AW each  beats to load into A, load into B, read from P; latched on accepted go_i.
REQ-007 busy_o  out  1  high whenever state is not IDLE; done_o  out  1  one-cycle pulse at job end.
REQ-008 s_valid_i  in  1, s_data_i  in  WW, s_ready_o  out  1  inbound word stream (A words, then B words).
REQ-009 m_valid_o  out  1, m_data_o  out  WW, m_last_o  out  1, m_ready_i  in  1  outbound P word stream.
REQ-010 ena_o, wea_o  out  1, addra_o  out  AW, worda_o  out  WW  buffer A write port; enb_o, web_o, addrb_o, wordb_o  likewise for buffer B.
REQ-011 enp_o, wep_o  out  1, addrp_o  out  AW, wordp_i  in  WW  buffer P read port; read data valid one cycle after enp_o.
REQ-012 tpu_start_o  out  1, tpu_valid_i  in  1; tpu_m_o, tpu_k_o, tpu_n_o, tpu_base_addra_o, tpu_base_addrb_o, tpu_base_addrp_o  out  AW  latched config to the accelerator.

Function
REQ-013 FSM states SHALL be IDLE, LOAD_A, LOAD_B, START, WAIT, READ_P, DRAIN.
REQ-014 IDLE->LOAD_A on go_i; zero lengths skip: lena=0 goes to LOAD_B, lenb=0 to START, lenp=0 from WAIT to DRAIN.
REQ-015 LOAD_A: s_ready_o=1; each handshake (s_valid_i&s_ready_o) SHALL drive ena_o=wea_o=1, addra_o=base_a+cnt (mod 2^AW), worda_o=s_data_i combinationally in that cycle; cnt++.
REQ-016 Handshake carrying beat lena-1 SHALL move to LOAD_B with cnt=0; LOAD_B identical on port B, ending in START.
REQ-017 s_ready_o SHALL be 0 outside LOAD_A/LOAD_B; en/we of A and B SHALL be 0 except on a handshake.
REQ-018 START SHALL assert tpu_start_o for exactly one cycle, then WAIT.
REQ-019 WAIT SHALL hold until tpu_valid_i=1, then READ_P with cnt=0.
REQ-020 READ_P: enp_o=1, wep_o=0, addrp_o=base_p+cnt issued only when the output skid buffer can accept one more word counting in-flight reads; cnt++ per issue.
REQ-021 Read data SHALL enter the skid buffer the cycle after issue; no word SHALL be dropped or duplicated under any m_ready_i pattern.
REQ-022 After lenp issues, state SHALL be DRAIN until the final word handshakes on m; m_last_o=1 with that word only.
REQ-023 On final m handshake (or on entering DRAIN with lenp=0): done_o=1 for one cycle, next state IDLE.
REQ-024 go_i while busy_o=1 SHALL be ignored; config SHALL stay stable until next accepted go_i.
REQ-025 Output stream SHALL sustain one word per cycle when m_ready_i=1 continuously.

Reset
REQ-026 rst_ni=0 at any clock edge, including mid-job, SHALL force IDLE, cnt=0, skid buffer empty, in-flight read discarded.
REQ-027 During and after reset: all outputs 0 (busy, done, s_ready, m_valid, m_last, tpu_start, all en/we), address/data/config outputs 0.

Structure
REQ-028 FSM state encoding SHALL be localparams; AW/WW SHALL come from the shared def.v header.
REQ-029 Output buffering SHALL be a separate sub-module stream_skid (2-entry, valid/ready both sides, WW+1 bits incl. last).

Verification
REQ-030 lena=2, lenb=3, base_a=0x10, base_b=0x20, s_valid stuck 1 -> A writes 0x10,0x11; B writes 0x20..0x22; tpu_start_o one pulse.
REQ-031 lenp=4, base_p=0x30, m_ready=1 -> reads 0x30..0x33, 4 m beats back-to-back, m_last on 4th, done_o the following cycle.
REQ-032 lenp=5, m_ready toggling 1,0,0,1... -> exactly the 5 P words, in order, no loss or duplicate.
REQ-033 lena=0, lenb=0, lenp=0 -> IDLE->START->WAIT; tpu_valid_i=1 -> done_o pulse, no buffer accesses, no m beats.
REQ-034 base_a=2^AW-1, lena=2 -> writes at 2^AW-1 then 0.
REQ-035 rst_ni=0 during READ_P with a read in flight -> next cycle all outputs 0, IDLE; following go_i runs a clean job.
